ysyx_23060229_regfile_sb: RTL and testbench
===========================================

# ysyx_23060229_regfile_sb

Parametrised general-purpose register file with PC register, write-to-read bypass and a per-register busy scoreboard. It is the pipelined-core successor of the single-cycle register block and sits between decode/issue (read ports, issue port) and writeback (write port).
- Decode uses the busy flags to stall on RAW hazards.
- The PC register gains a stall enable and a configurable reset vector.

## Interface
Parameters:
- ADDR_WIDTH, 5, register index width; the file holds 2**ADDR_WIDTH registers.
- DATA_WIDTH, 32, register and PC width.
- RESET_PC, 32'h80000000, PC value while reset is asserted.
- ZERO_REG, 1, when 1 register 0 reads 0, ignores writes and is never busy.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous and active-high.
- wen  in  1  writeback write enable.
- waddr  in  ADDR_WIDTH  writeback destination index.
- wdata  in  DATA_WIDTH  writeback data.
- raddr1, raddr2  in  ADDR_WIDTH  read indices.
- rdata1, rdata2  out  DATA_WIDTH  read data, combinational.
- rbusy1, rbusy2  out  1  source still pending (RAW hazard), combinational.
- iss_valid  in  1  an instruction with a destination issues this cycle.
- iss_rd  in  ADDR_WIDTH  destination index of the issuing instruction.
- flush  in  1  pipeline flush; clears all busy bits.
- pc_wen  in  1  PC update enable (low = stall).
- pc_next  in  DATA_WIDTH  next PC value.
- pc  out  DATA_WIDTH  current PC.

## Operation
- Storage: data array Reg[0..2**ADDR_WIDTH-1] of DATA_WIDTH bits; busy vector busy[0..2**ADDR_WIDTH-1].
- Write: at posedge, if wen and not (ZERO_REG and waddr==0), Reg[waddr] <= wdata.
- Read, per port n: rdata_n is computed in priority order:
  - 0 if ZERO_REG and raddr_n==0;
  - else wdata if wen and waddr==raddr_n (bypass);
  - else Reg[raddr_n].
- rbusy_n = busy[raddr_n] and not (wen and waddr==raddr_n). It is forced to 0 when ZERO_REG and raddr_n==0.
- iss_valid in the same cycle does not affect rbusy; the reader is older than the issuing instruction.
- Scoreboard update at posedge, applied in this priority:
  - flush: every busy bit is cleared, and the same-cycle issue is ignored; the write itself still lands in Reg.
  - iss_valid with iss_rd != 0 (or ZERO_REG==0): busy[iss_rd] <= 1. If wen targets the same index in the same cycle, set wins, because the new producer is younger.
  - wen: busy[waddr] <= 0, unless it is set by an issue in the same cycle.
- Issue to an already-busy register is legal (WAW). The bit stays 1 and is cleared by the first matching writeback; in-order writeback is the pipeline's responsibility.
- PC: at posedge, pc <= pc_next when pc_wen, otherwise it holds.
- Reset (rst high, asynchronous, at any time):
  - all Reg entries are 0;
  - all busy bits are 0;
  - pc = RESET_PC;
  - outputs follow combinationally (rdata from the zeroed array, rbusy = 0).
  - This holds mid-operation: pending busy bits are lost and in-flight writes are discarded while rst is high.
- Release: the first capturing edge is the first posedge with rst low.

## Timing
- Read data and busy flags: 0-cycle (combinational from raddr, wen, waddr, wdata and state).
- Write: architecturally visible through bypass in the same cycle, and from the array on the following cycle.
- Busy set: visible on rbusy the cycle after the iss_valid edge.
- Busy clear: visible on rbusy in the same cycle as wen (via bypass term); the state bit clears at that edge.
- PC: 1-cycle latency from pc_next/pc_wen to pc.
- No handshakes; every input is sampled every cycle. Callers must hold wen low when there is no writeback.

## Test plan
- Reset, then release. Required: pc==32'h80000000; rdata1/rdata2==0 for raddr 0..31; rbusy1/rbusy2==0. Then pulse rst asynchronously mid-cycle after writes and issues; state must clear immediately, before the next edge.
- Write x5=32'hDEADBEEF with raddr1=5 in the same cycle. Required: rdata1==32'hDEADBEEF that cycle and the following one. Write x0=32'h1234. Required: rdata reads 0.
- iss_valid with iss_rd=7. Next cycle raddr2=7 gives rbusy2==1. Then wen to x7 with 32'h55. Required: rbusy2==0 and rdata2==32'h55 in that cycle; the bit stays clear afterwards.
- Same cycle: iss_valid iss_rd=3 and wen waddr=3 wdata=9. Required: next cycle rbusy==1 for x3 and rdata==9.
- Issue x1, x2, x4, then flush together with iss_valid iss_rd=6. Required: next cycle all rbusy==0, including x6.
- pc_wen=1 with pc_next=32'h80000004, then pc_wen=0 with pc_next=32'hFFFF0000. Required: pc==32'h80000004 and it holds. Set ZERO_REG=0 and issue/write x0 with 32'hA5. Required: x0 reads 32'hA5 and busy behaves like any other register.

Source files
------------

// File: rtl/ysyx_23060229_regfile_sb.sv
// Register file with PC, same-cycle writeback bypass and a per-register busy
// scoreboard used by decode to detect RAW hazards.

module ysyx_23060229_regfile_sb_rport #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int ZERO_REG   = 1
) (
  input  logic [(2**ADDR_WIDTH)-1:0][DATA_WIDTH-1:0] regs,
  input  logic [(2**ADDR_WIDTH)-1:0]                 busy,
  input  logic [ADDR_WIDTH-1:0]                      raddr,
  input  logic                                       wen,
  input  logic [ADDR_WIDTH-1:0]                      waddr,
  input  logic [DATA_WIDTH-1:0]                      wdata,
  output logic [DATA_WIDTH-1:0]                      rdata,
  output logic                                       rbusy
);
  logic is_zero, hit;

  assign is_zero = (ZERO_REG != 0) && (raddr == '0);
  assign hit     = wen && (waddr == raddr);

  // Hard-wired x0 outranks the bypass, which outranks the array.
  always_comb begin
    rdata = regs[raddr];
    rbusy = busy[raddr] && !hit;
    if (hit) rdata = wdata;
    if (is_zero) begin
      rdata = '0;
      rbusy = 1'b0;
    end
  end
endmodule

module ysyx_23060229_regfile_sb #(
  parameter int                    ADDR_WIDTH = 5,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h80000000,
  parameter int                    ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] rdata2,
  output logic                  rbusy1,
  output logic                  rbusy2,
  input  logic                  iss_valid,
  input  logic [ADDR_WIDTH-1:0] iss_rd,
  input  logic                  flush,
  input  logic                  pc_wen,
  input  logic [DATA_WIDTH-1:0] pc_next,
  output logic [DATA_WIDTH-1:0] pc
);
  localparam int NREG  = 2**ADDR_WIDTH;
  localparam int NPORT = 2;

  logic [NREG-1:0][DATA_WIDTH-1:0]  regs;
  logic [NREG-1:0]                  busy;
  logic [NPORT-1:0][ADDR_WIDTH-1:0] raddr_v;
  logic [NPORT-1:0][DATA_WIDTH-1:0] rdata_v;
  logic [NPORT-1:0]                 rbusy_v;

  // A same-cycle issue beats a writeback clear: the issuer is the younger producer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '0;
      busy <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (!((ZERO_REG != 0) && (i == 0))) begin
          if (wen && (waddr == ADDR_WIDTH'(i))) regs[i] <= wdata;
          if (flush)                                          busy[i] <= 1'b0;
          else if (iss_valid && (iss_rd == ADDR_WIDTH'(i)))   busy[i] <= 1'b1;
          else if (wen && (waddr == ADDR_WIDTH'(i)))          busy[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         pc <= RESET_PC;
    else if (pc_wen) pc <= pc_next;
  end

  assign raddr_v = {raddr2, raddr1};
  assign rdata1  = rdata_v[0];
  assign rdata2  = rdata_v[1];
  assign rbusy1  = rbusy_v[0];
  assign rbusy2  = rbusy_v[1];

  for (genvar p = 0; p < NPORT; p++) begin : g_rport
    ysyx_23060229_regfile_sb_rport #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH),
      .ZERO_REG  (ZERO_REG)
    ) u_rport (
      .regs (regs),
      .busy (busy),
      .raddr(raddr_v[p]),
      .wen  (wen),
      .waddr(waddr),
      .wdata(wdata),
      .rdata(rdata_v[p]),
      .rbusy(rbusy_v[p])
    );
  end
endmodule

// File: tb/tb_ysyx_23060229_regfile_sb.sv
// Scoreboard bench: two instances (hard-wired x0 and plain x0) share one
// stimulus stream; a reference model predicts every cycle's outputs.

module tb_ysyx_23060229_regfile_sb;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wen = 1'b0, iss_valid = 1'b0, flush = 1'b0, pc_wen = 1'b0;
  logic [4:0]  waddr = '0, raddr1 = '0, raddr2 = '0, iss_rd = '0;
  logic [31:0] wdata = '0, pc_next = '0;

  logic [31:0] rd1_z, rd2_z, pc_z, rd1_n, rd2_n, pc_n;
  logic        rb1_z, rb2_z, rb1_n, rb2_n;

  always #5 clk = ~clk;

  ysyx_23060229_regfile_sb #(.ZERO_REG(1)) u_dut_z (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1_z), .rdata2(rd2_z),
    .rbusy1(rb1_z), .rbusy2(rb2_z), .iss_valid(iss_valid), .iss_rd(iss_rd),
    .flush(flush), .pc_wen(pc_wen), .pc_next(pc_next), .pc(pc_z));

  ysyx_23060229_regfile_sb #(.ZERO_REG(0)) u_dut_n (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1_n), .rdata2(rd2_n),
    .rbusy1(rb1_n), .rbusy2(rb2_n), .iss_valid(iss_valid), .iss_rd(iss_rd),
    .flush(flush), .pc_wen(pc_wen), .pc_next(pc_next), .pc(pc_n));

  typedef struct packed {
    logic [1:0][31:0] rd1;
    logic [1:0][31:0] rd2;
    logic [1:0]       rb1;
    logic [1:0]       rb2;
    logic [31:0]      pc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;

  // Reference model: index 0 models ZERO_REG=1, index 1 models ZERO_REG=0.
  logic [31:0] mreg  [2][32];
  logic        mbusy [2][32];
  logic [31:0] mpc;

  function automatic logic hard0(int d, logic [4:0] a);
    return (d == 0) && (a == 5'd0);
  endfunction

  task automatic m_reset();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 32; i++) begin
        mreg[d][i]  = 32'h0;
        mbusy[d][i] = 1'b0;
      end
    mpc = 32'h80000000;
  endtask

  function automatic logic [31:0] m_rd(int d, logic [4:0] a);
    if (hard0(d, a))         return 32'h0;
    if (wen && waddr == a)   return wdata;
    return mreg[d][a];
  endfunction

  function automatic logic m_rb(int d, logic [4:0] a);
    if (hard0(d, a)) return 1'b0;
    return mbusy[d][a] && !(wen && waddr == a);
  endfunction

  task automatic m_edge();
    for (int d = 0; d < 2; d++) begin
      if (wen && !hard0(d, waddr)) mreg[d][waddr] = wdata;
      if (flush) begin
        for (int i = 0; i < 32; i++) mbusy[d][i] = 1'b0;
      end else begin
        if (wen) mbusy[d][waddr] = 1'b0;
        if (iss_valid && !hard0(d, iss_rd)) mbusy[d][iss_rd] = 1'b1;
      end
    end
    if (pc_wen) mpc = pc_next;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s t=%0t actual=%h expected=%h", nm, $time, act, exp);
  endtask

  // Monitor: outputs are combinational, so every cycle presents a result.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("rdata1_zero", rd1_z, e.rd1[0]);
      chk("rdata2_zero", rd2_z, e.rd2[0]);
      chk("rbusy1_zero", {31'b0, rb1_z}, {31'b0, e.rb1[0]});
      chk("rbusy2_zero", {31'b0, rb2_z}, {31'b0, e.rb2[0]});
      chk("pc_zero", pc_z, e.pc);
      chk("rdata1_plain", rd1_n, e.rd1[1]);
      chk("rdata2_plain", rd2_n, e.rd2[1]);
      chk("rbusy1_plain", {31'b0, rb1_n}, {31'b0, e.rb1[1]});
      chk("rbusy2_plain", {31'b0, rb2_n}, {31'b0, e.rb2[1]});
      chk("pc_plain", pc_n, e.pc);
    end
  end

  // One cycle of stimulus; r=1 raises rst asynchronously mid-cycle.
  task automatic step(input logic r, input logic w, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2,
                      input logic iv, input logic [4:0] ird, input logic fl,
                      input logic pw, input logic [31:0] pn);
    exp_t e;
    if (!r) rst = 1'b0;
    wen = w; waddr = wa; wdata = wd; raddr1 = a1; raddr2 = a2;
    iss_valid = iv; iss_rd = ird; flush = fl; pc_wen = pw; pc_next = pn;
    if (r) begin
      #2;
      rst = 1'b1;
      m_reset();
    end
    for (int d = 0; d < 2; d++) begin
      e.rd1[d] = m_rd(d, a1);
      e.rd2[d] = m_rd(d, a2);
      e.rb1[d] = m_rb(d, a1);
      e.rb2[d] = m_rb(d, a2);
    end
    e.pc = mpc;
    q.push_back(e);
    @(posedge clk);
    if (!r) m_edge();
    #1;
  endtask

  initial begin
    logic r, w, iv;
    m_reset();
    @(posedge clk);
    #1;
    // Reset held: every index reads zero, not busy, PC at reset vector.
    for (int i = 0; i < 32; i++)
      step(1, 0, 0, 0, 5'(i), 5'(31 - i), 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 31, 0, 0, 0, 0, 0);
    // Write with bypass, then from the array.
    step(0, 1, 5, 32'hDEADBEEF, 5, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 5, 5, 0, 0, 0, 0, 0);
    step(0, 1, 0, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Busy set, then cleared by writeback (bypass term), then stays clear.
    step(0, 0, 0, 0, 0, 7, 1, 7, 0, 0, 0);
    step(0, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0);
    step(0, 1, 7, 32'h55, 0, 7, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0);
    // Issue and writeback to same index: set wins.
    step(0, 1, 3, 9, 3, 0, 1, 3, 0, 0, 0);
    step(0, 0, 0, 0, 3, 3, 0, 0, 0, 0, 0);
    // Flush drops pending bits and the same-cycle issue.
    step(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 1, 2, 0, 0, 0);
    step(0, 0, 0, 0, 1, 2, 1, 4, 0, 0, 0);
    step(0, 0, 0, 0, 4, 2, 1, 6, 1, 0, 0);
    step(0, 0, 0, 0, 6, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 2, 4, 0, 0, 0, 0, 0);
    // PC update then stall.
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h80000004);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF0000);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF0000);
    // x0 as an ordinary register on the plain instance.
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 32'hA5, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Async reset mid-operation after writes and issues.
    step(0, 1, 9, 32'h77, 9, 0, 1, 10, 0, 1, 32'h1000);
    step(0, 0, 0, 0, 9, 10, 1, 11, 0, 0, 0);
    step(1, 0, 0, 0, 9, 10, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 11, 5, 0, 0, 0, 0, 0);
    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      r  = ($urandom_range(0, 63) == 0);
      w  = r ? 1'b0 : 1'($urandom_range(0, 1));
      iv = 1'($urandom_range(0, 1));
      step(r, w, 5'($urandom), $urandom, 5'($urandom), 5'($urandom), iv,
           5'($urandom), ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)), $urandom);
    end
    @(negedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
